amp_adc_sequencer: RTL and testbench

Owns the shared SPI_SCK/SPI_MOSI bus between the LTC6912-1 programmable amplifier and the LTC1407A-1 dual ADC on the analog capture path. It accepts gain-write and sample requests from the control logic and arbitrates them onto the bus. It generates the amplifier chip-select and ADC conversion strobes, shifts out the 8-bit gain word, and deserialises both 14-bit ADC channels into parallel results.

---
 rtl/amp_adc_sequencer_if.sv | 24 ++
 rtl/amp_adc_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_amp_adc_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/amp_adc_sequencer_if.sv
// Request/result bundle between the capture control logic and amp_adc_sequencer.
// master = control logic side, slave = sequencer side.
interface amp_adc_sequencer_if;
  logic [3:0]  gain_a;
  logic [3:0]  gain_b;
  logic        gain_wr;
  logic        sample_req;
  logic [13:0] ch0;
  logic [13:0] ch1;
  logic        sample_valid;
  logic        gain_done;
  logic        busy;
  logic [7:0]  amp_readback;

  modport master (
    output gain_a, gain_b, gain_wr, sample_req,
    input  ch0, ch1, sample_valid, gain_done, busy, amp_readback
  );

  modport slave (
    input  gain_a, gain_b, gain_wr, sample_req,
    output ch0, ch1, sample_valid, gain_done, busy, amp_readback
  );
endinterface

// File: rtl/amp_adc_sequencer.sv
// Arbitrates LTC6912-1 gain writes and LTC1407A-1 conversions onto one shared SPI bus.
// Optional AMP_READBACK_EN: capture AMP_DOUT echo into amp_readback.
module amp_adc_sequencer #(
  parameter int SCK_DIV = 2
) (
  input  logic                       CLK50MHZ,
  input  logic                       RST,
  amp_adc_sequencer_if.slave         ctl,
  output logic                       SPI_SCK,
  output logic                       SPI_MOSI,
  output logic                       AMP_CS,
  output logic                       AMP_SHDN,
  input  logic                       AMP_DOUT,
  output logic                       AD_CONV,
  input  logic                       ADC_OUT
);

  typedef enum logic [2:0] {IDLE, AMP_XFER, AMP_END, CONV, ADC_XFER} state_t;

  localparam logic [8:0] HALF_M1 = 9'(SCK_DIV - 1);
  localparam logic [8:0] CONV_M1 = 9'(2 * SCK_DIV - 1);

  state_t      state_q, state_d;
  logic [8:0]  div_cnt_q, div_cnt_d;
  logic [5:0]  per_cnt_q, per_cnt_d;
  logic        sck_q, sck_d;
  logic        amp_cs_q, amp_cs_d;
  logic        ad_conv_q, ad_conv_d;
  logic        gain_pend_q, gain_pend_d;
  logic        samp_pend_q, samp_pend_d;
  logic [7:0]  word_q, word_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [31:0] adc_sh_q, adc_sh_d;
  logic [13:0] ch0_q, ch0_d;
  logic [13:0] ch1_q, ch1_d;
  logic        sample_valid_q, sample_valid_d;
  logic        gain_done_q, gain_done_d;
  logic        busy_q, busy_d;
`ifdef AMP_READBACK_EN
  logic [7:0]  rb_sh_q, rb_sh_d;
  logic [7:0]  amp_readback_q, amp_readback_d;
`endif

  always_comb begin
    state_d        = state_q;
    div_cnt_d      = div_cnt_q;
    per_cnt_d      = per_cnt_q;
    sck_d          = sck_q;
    amp_cs_d       = amp_cs_q;
    ad_conv_d      = ad_conv_q;
    gain_pend_d    = gain_pend_q;
    samp_pend_d    = samp_pend_q;
    word_d         = word_q;
    tx_sh_d        = tx_sh_q;
    adc_sh_d       = adc_sh_q;
    ch0_d          = ch0_q;
    ch1_d          = ch1_q;
    sample_valid_d = 1'b0;
    gain_done_d    = 1'b0;
`ifdef AMP_READBACK_EN
    rb_sh_d        = rb_sh_q;
    amp_readback_d = amp_readback_q;
`endif

    if (ctl.gain_wr) begin
      gain_pend_d = 1'b1;
      word_d      = {ctl.gain_b, ctl.gain_a};
    end
    if (ctl.sample_req) samp_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        per_cnt_d = '0;
        // A request arriving on the start cycle re-arms its flag rather than being lost.
        if (gain_pend_q) begin
          state_d     = AMP_XFER;
          gain_pend_d = ctl.gain_wr;
          amp_cs_d    = 1'b0;
          tx_sh_d     = word_q;
        end else if (samp_pend_q) begin
          state_d     = CONV;
          samp_pend_d = ctl.sample_req;
          ad_conv_d   = 1'b1;
        end
      end

      AMP_XFER: begin
        if (div_cnt_q == HALF_M1) begin
          div_cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
`ifdef AMP_READBACK_EN
            rb_sh_d = {rb_sh_q[6:0], AMP_DOUT};
`endif
          end else begin
            sck_d   = 1'b0;
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            if (per_cnt_q == 6'd7) begin
              per_cnt_d = '0;
              state_d   = AMP_END;
            end else begin
              per_cnt_d = per_cnt_q + 6'd1;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 9'd1;
        end
      end

      AMP_END: begin
        if (div_cnt_q == HALF_M1) begin
          div_cnt_d   = '0;
          amp_cs_d    = 1'b1;
          gain_done_d = 1'b1;
          state_d     = IDLE;
`ifdef AMP_READBACK_EN
          amp_readback_d = rb_sh_q;
`endif
        end else begin
          div_cnt_d = div_cnt_q + 9'd1;
        end
      end

      CONV: begin
        if (div_cnt_q == CONV_M1) begin
          div_cnt_d = '0;
          ad_conv_d = 1'b0;
          state_d   = ADC_XFER;
        end else begin
          div_cnt_d = div_cnt_q + 9'd1;
        end
      end

      ADC_XFER: begin
        // per_cnt == 34 is the one-cycle tail after the last falling edge.
        if (per_cnt_q == 6'd34) begin
          per_cnt_d      = '0;
          ch0_d          = adc_sh_q[31:18];
          ch1_d          = adc_sh_q[15:2];
          sample_valid_d = 1'b1;
          state_d        = IDLE;
        end else if (div_cnt_q == HALF_M1) begin
          div_cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d     = 1'b0;
            adc_sh_d  = {adc_sh_q[30:0], ADC_OUT};
            per_cnt_d = per_cnt_q + 6'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 9'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) begin
      state_q        <= IDLE;
      div_cnt_q      <= '0;
      per_cnt_q      <= '0;
      sck_q          <= 1'b0;
      amp_cs_q       <= 1'b1;
      ad_conv_q      <= 1'b0;
      gain_pend_q    <= 1'b0;
      samp_pend_q    <= 1'b0;
      word_q         <= '0;
      tx_sh_q        <= '0;
      adc_sh_q       <= '0;
      ch0_q          <= '0;
      ch1_q          <= '0;
      sample_valid_q <= 1'b0;
      gain_done_q    <= 1'b0;
      busy_q         <= 1'b0;
`ifdef AMP_READBACK_EN
      rb_sh_q        <= '0;
      amp_readback_q <= '0;
`endif
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      per_cnt_q      <= per_cnt_d;
      sck_q          <= sck_d;
      amp_cs_q       <= amp_cs_d;
      ad_conv_q      <= ad_conv_d;
      gain_pend_q    <= gain_pend_d;
      samp_pend_q    <= samp_pend_d;
      word_q         <= word_d;
      tx_sh_q        <= tx_sh_d;
      adc_sh_q       <= adc_sh_d;
      ch0_q          <= ch0_d;
      ch1_q          <= ch1_d;
      sample_valid_q <= sample_valid_d;
      gain_done_q    <= gain_done_d;
      busy_q         <= busy_d;
`ifdef AMP_READBACK_EN
      rb_sh_q        <= rb_sh_d;
      amp_readback_q <= amp_readback_d;
`endif
    end
  end

  assign SPI_SCK          = sck_q;
  assign SPI_MOSI         = tx_sh_q[7];
  assign AMP_CS           = amp_cs_q;
  assign AMP_SHDN         = 1'b0;
  assign AD_CONV          = ad_conv_q;
  assign ctl.ch0          = ch0_q;
  assign ctl.ch1          = ch1_q;
  assign ctl.sample_valid = sample_valid_q;
  assign ctl.gain_done    = gain_done_q;
  assign ctl.busy         = busy_q;

`ifdef AMP_READBACK_EN
  assign ctl.amp_readback = amp_readback_q;
`else
  logic unused_amp_dout;
  assign unused_amp_dout  = AMP_DOUT;
  assign ctl.amp_readback = 8'h00;
`endif

endmodule

// File: tb/tb_amp_adc_sequencer.sv
// Randomized bench for amp_adc_sequencer with behavioural LTC6912 and LTC1407A models.
module tb_amp_adc_sequencer;
  localparam int DIV = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sck, mosi, amp_cs, amp_shdn, ad_conv;
  logic amp_dout = 1'b0;
  logic adc_out  = 1'b0;

  amp_adc_sequencer_if ctl();

  amp_adc_sequencer #(.SCK_DIV(DIV)) dut (
    .CLK50MHZ (clk),
    .RST      (rst),
    .ctl      (ctl),
    .SPI_SCK  (sck),
    .SPI_MOSI (mosi),
    .AMP_CS   (amp_cs),
    .AMP_SHDN (amp_shdn),
    .AMP_DOUT (amp_dout),
    .AD_CONV  (ad_conv),
    .ADC_OUT  (adc_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event monitor: pulse counts, AD_CONV width, edge timestamps.
  int cyc = 0, sv_cnt = 0, gd_cnt = 0, conv_run = 0, conv_len = 0;
  int cs_rise_cyc = 0, conv_rise_cyc = 0;
  logic cs_prev = 1'b1, conv_prev = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (ctl.sample_valid) sv_cnt++;
    if (ctl.gain_done) gd_cnt++;
    if (ad_conv) conv_run++;
    else if (conv_run != 0) begin
      conv_len = conv_run;
      conv_run = 0;
    end
    if (amp_cs && !cs_prev) cs_rise_cyc = cyc;
    if (ad_conv && !conv_prev) conv_rise_cyc = cyc;
    cs_prev   = amp_cs;
    conv_prev = ad_conv;
  end

  // LTC6912 model: clocks MOSI in on SCK rise, echoes old register out on SCK fall.
  logic [7:0] amp_reg = 8'h00, amp_last_word = 8'h00;
  int amp_last_edges = 0;
  always begin
    logic [7:0] word_in, out_sh;
    int edges;
    @(negedge amp_cs);
    word_in  = 8'h00;
    edges    = 0;
    out_sh   = amp_reg;
    amp_dout = out_sh[7];
    forever begin
      @(posedge sck or negedge sck or posedge amp_cs);
      if (amp_cs) break;
      if (sck) begin
        word_in = {word_in[6:0], mosi};
        edges++;
      end else begin
        #1;
        out_sh   = out_sh << 1;
        amp_dout = out_sh[7];
      end
    end
    amp_last_word  = word_in;
    amp_last_edges = edges;
    if (edges == 8) amp_reg = word_in;
  end

  // LTC1407A model: one bit per SCK period, new bit after each SCK fall.
  logic [13:0] adc_c0 = 14'h0, adc_c1 = 14'h0;
  always begin
    logic [33:0] frame;
    logic [5:0]  junk;
    int k;
    @(negedge ad_conv);
    junk    = 6'($urandom);
    frame   = {junk[1:0], adc_c0, junk[3:2], adc_c1, junk[5:4]};
    k       = 1;
    adc_out = frame[33];
    while (k < 34) begin
      @(negedge sck or posedge rst);
      if (rst) break;
      #1;
      k++;
      adc_out = frame[34-k];
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse(input logic g, input logic s, input logic [3:0] a, input logic [3:0] b);
    @(posedge clk); #1;
    ctl.gain_a = a; ctl.gain_b = b; ctl.gain_wr = g; ctl.sample_req = s;
    @(posedge clk); #1;
    ctl.gain_wr = 1'b0; ctl.sample_req = 1'b0;
  endtask

  task automatic do_gain(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] prev;
    int n;
    prev = amp_reg;
    pulse(1'b1, 1'b0, a, b);
    n = 0;
    while (n < 2000) begin
      @(posedge clk); n++; #1;
      if (ctl.gain_done) break;
    end
    check("gain_latency", n, 1 + 17*DIV);
    check("amp_word", amp_last_word, {b, a});
    check("amp_edges", amp_last_edges, 8);
`ifdef AMP_READBACK_EN
    check("amp_readback", ctl.amp_readback, prev);
`else
    check("amp_readback", ctl.amp_readback, 8'h00);
`endif
    idle(3);
  endtask

  task automatic do_sample(input logic [13:0] c0, input logic [13:0] c1);
    int n;
    adc_c0 = c0;
    adc_c1 = c1;
    pulse(1'b0, 1'b1, 4'h0, 4'h0);
    n = 0;
    while (n < 2000) begin
      @(posedge clk); n++; #1;
      if (ctl.sample_valid) break;
    end
    check("sample_latency", n, 2 + 70*DIV);
    check("ch0", ctl.ch0, c0);
    check("ch1", ctl.ch1, c1);
    check("busy_at_valid", ctl.busy, 1'b0);
    check("conv_width", conv_len, 2*DIV);
    idle(3);
  endtask

  initial begin
    int s0, g0, n;
    ctl.gain_a = 4'h0; ctl.gain_b = 4'h0; ctl.gain_wr = 1'b0; ctl.sample_req = 1'b0;
    idle(3);
    #1;
    check("rst_pins", {sck, mosi, amp_cs, amp_shdn, ad_conv}, 5'b00100);
    check("rst_ch", {ctl.ch0, ctl.ch1}, 28'h0);
    check("rst_flags", {ctl.sample_valid, ctl.gain_done, ctl.busy}, 3'b000);
    check("rst_readback", ctl.amp_readback, 8'h00);
    @(negedge clk) rst = 1'b0;
    idle(2);

    do_gain(4'h1, 4'h2);
    do_sample(14'h1ABC, 14'h2001);
    do_gain(4'h3, 4'h4);
`ifdef AMP_READBACK_EN
    check("readback_21", ctl.amp_readback, 8'h21);
`else
    check("readback_tied", ctl.amp_readback, 8'h00);
`endif

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) do_gain(4'($urandom), 4'($urandom));
      else do_sample(14'($urandom), 14'($urandom));
    end

    // Simultaneous requests: amplifier first, one idle cycle, then conversion.
    adc_c0 = 14'h0F0F; adc_c1 = 14'h3333;
    g0 = gd_cnt; s0 = sv_cnt;
    pulse(1'b1, 1'b1, 4'h5, 4'h6);
    n = 0;
    while (n < 3000 && sv_cnt == s0) begin @(posedge clk); n++; end
    idle(20);
    check("both_gain_done", gd_cnt - g0, 1);
    check("both_sample_valid", sv_cnt - s0, 1);
    check("both_gap", conv_rise_cyc - cs_rise_cyc, 1);
    check("both_word", amp_last_word, 8'h65);
    check("both_ch0", ctl.ch0, 14'h0F0F);
    check("both_ch1", ctl.ch1, 14'h3333);

    // Three requests during one ADC_XFER merge into one more conversion.
    adc_c0 = 14'h0123; adc_c1 = 14'h1357;
    s0 = sv_cnt;
    pulse(1'b0, 1'b1, 4'h0, 4'h0);
    idle(2*DIV + 10);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b1, 4'h0, 4'h0);
      idle(5);
    end
    idle(700);
    check("merged_valids", sv_cnt - s0, 2);
    check("merged_ch0", ctl.ch0, 14'h0123);

    // Reset during SCK period 10 of ADC_XFER.
    adc_c0 = 14'h2AAA; adc_c1 = 14'h1555;
    pulse(1'b0, 1'b1, 4'h0, 4'h0);
    repeat (1 + 2*DIV + 19*DIV) @(posedge clk);
    #2;
    check("p10_sck_high", sck, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_sck", sck, 1'b0);
    check("rst_mid_conv", ad_conv, 1'b0);
    check("rst_mid_ch0", ctl.ch0, 14'h0);
    check("rst_mid_cs_busy", {amp_cs, ctl.busy}, 2'b10);
    @(negedge clk) rst = 1'b0;
    s0 = sv_cnt;
    idle(300);
    check("rst_no_valid", sv_cnt - s0, 0);
    do_sample(14'($urandom), 14'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1);
  end
endmodule
